// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded operands/control, applies EX/MEM and
// MEM/WB forwarding on the latched source indices, and drives the ALU inputs.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_alu_ctrl,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_branch,
  input  logic              ex_ready,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              ex_valid,
  output logic [DATA_W-1:0] in_alu_1,
  output logic [DATA_W-1:0] in_alu_2,
  output logic [2:0]        alu_ctrl,
  output logic [DATA_W-1:0] ex_rt_fwd,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_branch,
  output logic              ex_illegal
);

  logic              r_valid;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic [2:0]        r_alu_ctrl;
  logic              r_alu_src;
  logic              r_reg_write;
  logic              r_branch;

  logic              w_accept;
  logic              w_illegal;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  // in_ready deliberately ignores flush: decode sees the same back-pressure either way
  assign in_ready = !r_valid || ex_ready;
  assign w_accept = in_valid && in_ready;

  // Pipeline slot update: flush beats accept, accept loads, drain empties, stall holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_alu_ctrl  <= '0;
      r_alu_src   <= 1'b0;
      r_reg_write <= 1'b0;
      r_branch    <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_rs_data   <= id_rs_data;
      r_rt_data   <= id_rt_data;
      r_imm       <= id_imm;
      r_rs        <= id_rs;
      r_rt        <= id_rt;
      r_rd        <= id_rd;
      r_alu_ctrl  <= id_alu_ctrl;
      r_alu_src   <= id_alu_src;
      r_reg_write <= id_reg_write;
      r_branch    <= id_branch;
    end else if (ex_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Operand forwarding on the latched indices; EX/MEM is newer so it wins, r0 never forwards
  always_comb begin
    w_fwd_rs = r_rs_data;
    if (exmem_reg_write && (exmem_rd == r_rs) && (r_rs != '0)) begin
      w_fwd_rs = exmem_result;
    end else if (memwb_reg_write && (memwb_rd == r_rs) && (r_rs != '0)) begin
      w_fwd_rs = memwb_result;
    end
    w_fwd_rt = r_rt_data;
    if (exmem_reg_write && (exmem_rd == r_rt) && (r_rt != '0)) begin
      w_fwd_rt = exmem_result;
    end else if (memwb_reg_write && (memwb_rd == r_rt) && (r_rt != '0)) begin
      w_fwd_rt = memwb_result;
    end
  end

  assign w_illegal = r_valid && (r_alu_ctrl[2:1] == 2'b11);

  // Outputs are zeroed while the slot is empty so a bubble looks like a no-op
  always_comb begin
    ex_valid     = r_valid;
    ex_rd        = r_rd;
    ex_illegal   = w_illegal;
    in_alu_1     = '0;
    in_alu_2     = '0;
    alu_ctrl     = '0;
    ex_rt_fwd    = '0;
    ex_reg_write = 1'b0;
    ex_branch    = 1'b0;
    if (r_valid) begin
      in_alu_1     = w_fwd_rs;
      in_alu_2     = r_alu_src ? r_imm : w_fwd_rt;
      alu_ctrl     = r_alu_ctrl;
      ex_rt_fwd    = w_fwd_rt;
      ex_reg_write = r_reg_write && !w_illegal;
      ex_branch    = r_branch;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed steps plus randomized traffic
// checked against a behavioural model of the slot and forwarding rules.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [2:0]  id_alu_ctrl;
  logic        id_alu_src, id_reg_write, id_branch;
  logic        ex_ready, flush;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        ex_valid;
  logic [31:0] in_alu_1, in_alu_2, ex_rt_fwd;
  logic [2:0]  alu_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_branch, ex_illegal;

  int tests = 0;
  int fails = 0;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_ctrl(id_alu_ctrl),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_branch(id_branch),
    .ex_ready(ex_ready), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .in_alu_1(in_alu_1), .in_alu_2(in_alu_2), .alu_ctrl(alu_ctrl),
    .ex_rt_fwd(ex_rt_fwd), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_branch(ex_branch), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  // Model: the instruction currently held in EX, or none
  typedef struct {
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic [2:0]  ctrl;
    logic        src, rw, br;
  } instr_t;

  instr_t m_ins;
  bit     m_live;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] value_of(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return rf;
    if (exmem_reg_write && exmem_rd == idx) return exmem_result;
    if (memwb_reg_write && memwb_rd == idx) return memwb_result;
    return rf;
  endfunction

  task automatic model_reset();
    m_live = 0;
    m_ins = '{rs_data: 0, rt_data: 0, imm: 0, rs: 0, rt: 0, rd: 0, ctrl: 0,
              src: 0, rw: 0, br: 0};
  endtask

  task automatic check_all(input string tag);
    bit          bad;
    logic [31:0] a, b, t;
    bad = m_live && (m_ins.ctrl >= 3'd6);
    a = m_live ? value_of(m_ins.rs, m_ins.rs_data) : 32'd0;
    t = m_live ? value_of(m_ins.rt, m_ins.rt_data) : 32'd0;
    b = !m_live ? 32'd0 : (m_ins.src ? m_ins.imm : t);
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, !m_live || ex_ready});
    chk({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, m_live});
    chk({tag, ".alu1"}, in_alu_1, a);
    chk({tag, ".alu2"}, in_alu_2, b);
    chk({tag, ".rtfwd"}, ex_rt_fwd, t);
    chk({tag, ".ctrl"}, {29'd0, alu_ctrl}, m_live ? {29'd0, m_ins.ctrl} : 32'd0);
    chk({tag, ".rd"}, {27'd0, ex_rd}, {27'd0, m_ins.rd});
    chk({tag, ".rw"}, {31'd0, ex_reg_write}, {31'd0, m_live && m_ins.rw && !bad});
    chk({tag, ".br"}, {31'd0, ex_branch}, {31'd0, m_live && m_ins.br});
    chk({tag, ".ill"}, {31'd0, ex_illegal}, {31'd0, bad});
  endtask

  // Check current outputs, advance the model by the rules, then cross one edge
  task automatic step(input string tag);
    #1;
    check_all(tag);
    if (flush) m_live = 0;
    else if (in_valid && (!m_live || ex_ready)) begin
      m_live = 1;
      m_ins = '{rs_data: id_rs_data, rt_data: id_rt_data, imm: id_imm, rs: id_rs,
                rt: id_rt, rd: id_rd, ctrl: id_alu_ctrl, src: id_alu_src,
                rw: id_reg_write, br: id_branch};
    end else if (ex_ready) m_live = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_id(input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [2:0] ctrl, input logic src, input logic rw);
    in_valid = 1; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_rs = rs; id_rt = rt; id_rd = rd; id_alu_ctrl = ctrl;
    id_alu_src = src; id_reg_write = rw; id_branch = 0;
  endtask

  task automatic no_fwd();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  initial begin
    logic [31:0] held;
    rst = 1; in_valid = 0; ex_ready = 1; flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 0;
    no_fwd();
    model_reset();
    @(negedge clk);
    #1 check_all("reset");
    rst = 0;
    @(negedge clk);

    // Basic ADD load, one-cycle latency
    set_id(32'hE, 32'h19, 0, 1, 2, 4, 3'b010, 0, 1);
    step("add_issue");
    in_valid = 0;
    #1;
    chk("add.alu1", in_alu_1, 32'hE);
    chk("add.alu2", in_alu_2, 32'h19);
    chk("add.ctrl", {29'd0, alu_ctrl}, 32'd2);

    // Forwarding priority on a held rs=3
    set_id(32'h1, 32'h2, 0, 3, 5, 6, 3'b010, 0, 1);
    step("fwd_issue");
    in_valid = 0; ex_ready = 0;
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hF;
    memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'h8;
    #1 chk("fwd.exmem_wins", in_alu_1, 32'hF);
    exmem_reg_write = 0;
    #1 chk("fwd.memwb", in_alu_1, 32'h8);
    step("fwd_hold");
    ex_ready = 1; no_fwd();
    step("fwd_drain");

    // r0 never forwards; immediate select leaves ex_rt_fwd on rt
    set_id(0, 32'h77, 32'hFFFF_FFFC, 0, 7, 8, 3'b010, 1, 1);
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'h5;
    step("r0_issue");
    in_valid = 0;
    #1;
    chk("r0.alu1", in_alu_1, 32'h0);
    chk("imm.alu2", in_alu_2, 32'hFFFF_FFFC);
    chk("imm.rtfwd", ex_rt_fwd, 32'h77);
    no_fwd();

    // Stall 3 cycles with a waiting instruction; MEM/WB result on rt is picked up
    set_id(32'hA, 32'hB, 0, 9, 10, 11, 3'b011, 0, 1);
    step("stall_issue");
    ex_ready = 0;
    set_id(32'hC0, 32'hC1, 0, 12, 13, 14, 3'b000, 0, 1);
    for (int i = 0; i < 3; i++) begin
      memwb_reg_write = 1; memwb_rd = 10; memwb_result = 32'h100 + i;
      #1;
      chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall.alu1", in_alu_1, 32'hA);
      chk("stall.alu2", in_alu_2, 32'h100 + i);
      step("stall");
    end
    ex_ready = 1; no_fwd();
    step("stall_release");
    in_valid = 0;
    #1 chk("release.alu1", in_alu_1, 32'hC0);

    // Flush during an accept
    set_id(32'h55, 32'h66, 0, 1, 2, 3, 3'b001, 0, 1);
    flush = 1;
    step("flush");
    flush = 0; in_valid = 0;
    #1;
    chk("flush.valid", {31'd0, ex_valid}, 32'd0);
    chk("flush.alu1", in_alu_1, 32'd0);

    // Illegal op suppresses write enable
    set_id(32'h3, 32'h4, 0, 1, 2, 3, 3'b111, 0, 1);
    step("ill_issue");
    in_valid = 0;
    #1;
    chk("ill.flag", {31'd0, ex_illegal}, 32'd1);
    chk("ill.rw", {31'd0, ex_reg_write}, 32'd0);
    chk("ill.ctrl", {29'd0, alu_ctrl}, 32'd7);

    // Async reset in the middle of a stall
    ex_ready = 0;
    step("pre_rst");
    #2 rst = 1;
    #1;
    chk("rst_async.valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_async.alu1", in_alu_1, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 0; ex_ready = 1;
    @(negedge clk);

    // Randomized traffic with a narrow index range so forwarding hazards are common
    held = 0;
    for (int n = 0; n < 400; n++) begin
      set_id($urandom, $urandom, $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 1'($urandom),
             1'($urandom));
      id_branch = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 7) == 0);
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3));
      exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3));
      memwb_result = $urandom;
      step("rand");
      held = held + 1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register that feeds the ALU: latches decoded operands and control, then drives in_alu_1, in_alu_2 and alu_ctrl.
- Operands are corrected by forwarding from the EX/MEM and MEM/WB stages.
- Valid/ready handshake toward decode; stall back-pressure from downstream; flush for branch squash.
- Sits between the decoder/register-file read and the ALU; the ALU's zero and alu_result go to EX/MEM.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register index width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage can accept this cycle
id_rs_data  in  DATA_W  register-file read of rs
id_rt_data  in  DATA_W  register-file read of rt
id_imm  in  DATA_W  sign-extended immediate
id_rs  in  REG_AW  rs index
id_rt  in  REG_AW  rt index
id_rd  in  REG_AW  destination index
id_alu_ctrl  in  3  ALU op: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 BEQ, 101 NOR
id_alu_src  in  1  1 = in_alu_2 takes immediate
id_reg_write  in  1  instruction writes rd
id_branch  in  1  instruction is a branch
ex_ready  in  1  downstream accepts the current EX instruction
flush  in  1  squash the EX-stage slot
exmem_reg_write  in  1  EX/MEM writes back
exmem_rd  in  REG_AW  EX/MEM destination
exmem_result  in  DATA_W  EX/MEM ALU result
memwb_reg_write  in  1  MEM/WB writes back
memwb_rd  in  REG_AW  MEM/WB destination
memwb_result  in  DATA_W  MEM/WB writeback data
ex_valid  out  1  EX slot holds a live instruction
in_alu_1  out  DATA_W  ALU operand A
in_alu_2  out  DATA_W  ALU operand B
alu_ctrl  out  3  ALU operation
ex_rt_fwd  out  DATA_W  forwarded rt value (store data)
ex_rd  out  REG_AW  latched destination
ex_reg_write  out  1  qualified write enable
ex_branch  out  1  qualified branch flag
ex_illegal  out  1  latched alu_ctrl is 110 or 111

Behaviour:
- Reset (async, immediate): ex_valid=0; all stored fields are cleared to 0. All outputs therefore read 0, and in_ready=1.
- in_ready = !ex_valid || ex_ready. Combinational, with no dependence on in_valid.
- Accept = in_valid && in_ready.
  - On accept: all id_* fields load and ex_valid=1 next cycle.
  - If !accept and ex_ready: ex_valid=0 next cycle.
  - If ex_valid && !ex_ready: hold all fields unchanged.
- flush has the highest priority. On the next edge ex_valid=0 and nothing loads, even when accept is true that cycle. in_ready is not affected by flush.
- Latency: one cycle from accept to the values appearing on the ALU-facing outputs.
- Forwarding is combinational on the latched rs/rt, evaluated every cycle so a held instruction picks up newly arriving results. For operand X ∈ {rs, rt}:
  - If exmem_reg_write && exmem_rd==X && X!=0, use exmem_result.
  - Else if memwb_reg_write && memwb_rd==X && X!=0, use memwb_result.
  - Else use the latched register-file data.
  - EX/MEM wins when both stages match.
- in_alu_1 = fwd(rs).
- in_alu_2 = id_alu_src ? latched imm : fwd(rt).
- ex_rt_fwd = fwd(rt), regardless of alu_src.
- When ex_valid=0, these outputs are forced to 0: in_alu_1, in_alu_2, alu_ctrl, ex_rt_fwd, ex_reg_write, ex_branch, ex_illegal.
- ex_illegal = ex_valid && latched alu_ctrl ∈ {110,111}. When ex_illegal=1, ex_reg_write is forced 0; alu_ctrl still passes through.
- Register 0: a latched rd of 0 passes through unchanged. A source index of 0 never forwards.
- Reset asserted mid-stall drops the held instruction.

Test Plan:
- Reset then in_valid=1 with rs_data=0xE, rt_data=0x19, alu_ctrl=010, alu_src=0 → next cycle ex_valid=1, in_alu_1=0xE, in_alu_2=0x19, alu_ctrl=010.
- Latched rs=3 with exmem_reg_write=1, exmem_rd=3, exmem_result=0xF, and memwb_rd=3, memwb_result=0x8 → in_alu_1=0xF. With exmem_reg_write dropped → in_alu_1=0x8.
- rs=0 with exmem_reg_write=1, exmem_rd=0, exmem_result=0x5, rs_data=0 → in_alu_1=0. alu_src=1, imm=0xFFFFFFFC → in_alu_2=0xFFFFFFFC, while ex_rt_fwd = rt value.
- ex_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs held constant. Meanwhile memwb_result changes to a matching rt → in_alu_2 follows. ex_ready=1 → next instruction loads on that edge.
- flush=1 in the same cycle as an accept → next cycle ex_valid=0 and every ALU output is 0. rst pulsed mid-stall → ex_valid=0 immediately, without waiting for a clock edge.
- alu_ctrl=111, reg_write=1 → ex_illegal=1, ex_reg_write=0.
